cram_loader: RTL
================

Name: cram_loader

Overview:
- Configuration-memory loader that sits directly upstream of a chain of logic elements (LEs).
- Accepts the bitstream from a host as WORD_W-bit words over a valid/ready handshake and serialises it MSB-first into the LE config shift chain (drives config_data_in / config_en of the first LE).
- Captures the bits that fall out of the chain tail (config_data_out of the last LE) as readback of the previous configuration.
- Holds the LEs in reset while loading, then releases them.

Parameters:
CHAIN_LEN, 17, total config bits in the chain (16 LUT bits + 1 mode bit per LE × number of LEs); must be >= 1.
WORD_W, 8, host word width; must be >= 1.
LE_RST_CYCLES, 2, cycles le_nrst stays low after the last config bit before release; must be >= 1.

Ports:
clk  in  1  single clock for the loader and the config chain.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a load; sampled only in IDLE.
busy  out  1  high from the cycle after start is accepted through the DONE cycle.
done  out  1  one-cycle pulse when the load completes and the LEs are released.
word_valid  in  1  host word available.
word_ready  out  1  loader can accept a word.
word_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
cfg_en  out  1  to config_en of the chain; high exactly on cycles where the chain shifts.
cfg_data  out  1  to config_data_in of the first LE.
cfg_tail  in  1  from config_data_out of the last LE.
le_nrst  out  1  active-low reset to the LEs.
le_en  out  1  enable to the LEs.
rb_data  out  CHAIN_LEN  readback of the previous chain contents.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE; busy=0, done=0, word_ready=0, cfg_en=0, cfg_data=0;
  - le_nrst=0, le_en=0 (LEs stay in reset until the first completed load);
  - rb_data=0; bit and word counters cleared.
- States: IDLE, LOAD_WORD, SHIFT, RELEASE, DONE.
- IDLE:
  - start=1 -> LOAD_WORD.
  - On the same edge: le_nrst<=0, le_en<=0, remaining<=CHAIN_LEN.
- LOAD_WORD:
  - word_ready=1 (combinational from state); cfg_en=0.
  - word_valid&&word_ready -> latch word_data into the shift register; bits_left<=min(WORD_W, remaining) -> SHIFT.
  - word_valid=0: stall indefinitely; no chain activity.
- SHIFT:
  - cfg_en=1; cfg_data=shreg[WORD_W-1] (combinational from registers).
  - Each edge: shreg<<=1; remaining--; bits_left--; rb_data<={rb_data[CHAIN_LEN-2:0], cfg_tail}.
  - bits_left reaches 0 with remaining>0 -> LOAD_WORD.
  - remaining reaches 0 -> RELEASE.
- Final word: only its top `remaining` bits are used; the low padding bits are discarded and never shifted.
- Total cfg_en-high cycles per load is exactly CHAIN_LEN; the cycles may be non-contiguous when the host stalls.
- Readback ordering: after a full load, rb_data equals the bit stream of the previous load in load order (rb_data[CHAIN_LEN-1] = first bit loaded last time). After the first load following reset, rb_data reflects the chain's reset contents.
- RELEASE:
  - le_nrst=0 for exactly LE_RST_CYCLES cycles -> DONE.
- DONE (one cycle):
  - done=1, busy=1, le_nrst<=1, le_en<=1 (le_nrst/le_en high from this cycle on).
  - Next state IDLE.
- Latency with word_valid held high: start edge to done cycle = CHAIN_LEN + ceil(CHAIN_LEN/WORD_W) + LE_RST_CYCLES + 1 cycles. Defaults: 17+3+2+1 = 23.
- start outside IDLE is ignored; no queuing.
- word_data and word_valid are ignored when word_ready=0.
- rst mid-load:
  - immediate return to reset values; le_nrst=0 and le_en=0;
  - chain contents are undefined and the host must reload;
  - partial rb_data is discarded (cleared to 0).
- le_nrst and le_en are registered outputs; no combinational path from inputs to them.

Test Plan:
1. Reset, start, words 0x69,0x96,0x80 (CHAIN_LEN=17) with valid held high -> cfg_en high 17 cycles, in 3 bursts of 8,8,1. cfg_data stream = 0110100110010110 then 1. done on cycle 23 after start. le_nrst=1, le_en=1 from done.
2. Second load of 0x00,0x01,0x00 after test 1 -> rb_data=17'h0D32D (the previous stream). The 17-bit shift-register chain model shows 0x0001 LUT content with mode bit 0.
3. Host stall: word_valid low for 5 cycles before word 2 -> cfg_en low and cfg_data ignored during the stall. Load still completes correctly; done at cycle 28.
4. start pulsed during SHIFT and during DONE -> ignored; exactly one done pulse, no second load.
5. rst asserted mid-SHIFT (after 5 bits) -> next cycle state IDLE, busy=0, cfg_en=0, le_nrst=0, le_en=0, rb_data=0. A new start with a full load succeeds.
6. CHAIN_LEN=16, WORD_W=8 -> exactly 2 words accepted; no third word_ready; done at cycle 16+2+2+1=21.

Source files
------------

// File: rtl/cram_loader.sv
// Configuration-memory loader: takes host words over valid/ready, shifts them MSB-first
// into the LE config chain, captures the chain tail as readback, then releases the LEs.
module cram_loader #(
  parameter int CHAIN_LEN     = 17,
  parameter int WORD_W        = 8,
  parameter int LE_RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic [WORD_W-1:0]    word_data,
  output logic                 cfg_en,
  output logic                 cfg_data,
  input  logic                 cfg_tail,
  output logic                 le_nrst,
  output logic                 le_en,
  output logic [CHAIN_LEN-1:0] rb_data
);

  localparam int REM_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int REL_W = $clog2(LE_RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WORD,
    S_SHIFT,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [WORD_W-1:0]    shreg_q;
  logic [REM_W-1:0]     remaining_q;
  logic [BIT_W-1:0]     bits_left_q;
  logic [REL_W-1:0]     rel_cnt_q;
  logic [CHAIN_LEN-1:0] rb_q;
  logic [CHAIN_LEN-1:0] rb_d;
  logic                 le_nrst_q;
  logic                 le_en_q;

  // Bits to take from the next word: a full word, or only the top bits of the last one.
  function automatic logic [BIT_W-1:0] word_bits(input logic [REM_W-1:0] rem);
    if (int'(rem) >= WORD_W) return BIT_W'(WORD_W);
    else                     return BIT_W'(rem);
  endfunction

  always_comb begin
    rb_d    = '0;
    rb_d[0] = cfg_tail;
    for (int i = 1; i < CHAIN_LEN; i++) rb_d[i] = rb_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      bits_left_q <= '0;
      rel_cnt_q   <= '0;
      rb_q        <= '0;
      le_nrst_q   <= 1'b0;
      le_en_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD_WORD;
            le_nrst_q   <= 1'b0;
            le_en_q     <= 1'b0;
            remaining_q <= REM_W'(CHAIN_LEN);
          end
        end
        S_LOAD_WORD: begin
          if (word_valid) begin
            bits_left_q <= word_bits(remaining_q);
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          remaining_q <= remaining_q - REM_W'(1);
          bits_left_q <= bits_left_q - BIT_W'(1);
          rb_q        <= rb_d;
          if (remaining_q == REM_W'(1)) begin
            state_q   <= S_RELEASE;
            rel_cnt_q <= REL_W'(LE_RST_CYCLES - 1);
          end else if (bits_left_q == BIT_W'(1)) begin
            state_q <= S_LOAD_WORD;
          end
        end
        S_RELEASE: begin
          // LEs come out of reset on the same edge that enters DONE.
          if (rel_cnt_q == '0) begin
            state_q   <= S_DONE;
            le_nrst_q <= 1'b1;
            le_en_q   <= 1'b1;
          end else begin
            rel_cnt_q <= rel_cnt_q - REL_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Shift register is pure data; the state gating on cfg_data hides its contents otherwise.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_WORD && word_valid) shreg_q <= word_data;
    else if (state_q == S_SHIFT)              shreg_q <= shreg_q << 1;
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign word_ready = (state_q == S_LOAD_WORD);
  assign cfg_en     = (state_q == S_SHIFT);
  assign cfg_data   = (state_q == S_SHIFT) && shreg_q[WORD_W-1];
  assign le_nrst    = le_nrst_q;
  assign le_en      = le_en_q;
  assign rb_data    = rb_q;

endmodule
